// File: rtl/internal_node_readout.sv
// internal_node_readout: reads NODE_COUNT node RAM entries and serialises each into FETCH_WIDTH words, LSB slice first.
// Latency: FETCH and LATCH take one cycle each, then one cycle per word. Minimum FETCH_WIDTH+2 cycles per node, plus one DONE cycle.
// Backpressure: a word moves only when receiver_full_n=1. While it is low, the word index and receiver_data are held.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   start               begin a full readout; sampled only when idle
//   busy, done          busy in every non-idle state; done pulses for one cycle at the end
//   ram_ren, ram_radr   node RAM read port; ram_radr holds its value between fetches
//   ram_rdata           node RAM data, valid one cycle after ram_ren
//   receiver_data/enq   word to the downstream FIFO and its transfer strobe
//   receiver_full_n     downstream can accept a word this cycle
module internal_node_readout #(
  parameter int DATA_WIDTH    = 11,
  parameter int FETCH_WIDTH   = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NODE_COUNT    = 63
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              ram_ren,
  output logic [ADDRESS_WIDTH-1:0]          ram_radr,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq
);

  localparam int WORD_IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NODE_COUNT - 1);
  localparam logic [WORD_IDX_W-1:0]    LAST_WORD = WORD_IDX_W'(FETCH_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                            state;
  logic [ADDRESS_WIDTH-1:0]          node_adr;
  logic [WORD_IDX_W-1:0]             word_idx;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0]             words [FETCH_WIDTH];

  // Split the holding register into word slices. Slice 0 is the LSBs.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_split
    assign words[i] = hold[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // The read address is the node counter itself. It changes only when entering FETCH,
  // so it holds the last fetched address at all other times.
  assign ram_radr      = node_adr;
  assign receiver_data = words[word_idx];
  assign receiver_enq  = (state == SEND) && receiver_full_n;

  // busy, done and ram_ren are registered. Each is loaded together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      node_adr <= '0;
      word_idx <= '0;
      hold     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_ren  <= 1'b0;
    end else begin
      done    <= 1'b0;
      ram_ren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            node_adr <= '0;
            busy     <= 1'b1;
            ram_ren  <= 1'b1;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          hold     <= ram_rdata;
          word_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (receiver_full_n) begin
            if (word_idx != LAST_WORD) begin
              word_idx <= word_idx + 1'b1;
            end else if (node_adr == LAST_ADDR) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              node_adr <= node_adr + 1'b1;
              state    <= FETCH;
              ram_ren  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
